mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, is the number of WAIT-state cycles without dm_ack before an access is aborted.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 Inputs from the EX/MEM register, all 1 bit unless stated:
  - mem_write_enable, mem_read_enable
  - is_branch, sel_jflag_branch, sel_beq_bne, sel_jt_jf
  - reg_write_enable; wb_res_mux 2 bits
  - flags 6 bits: [0] zero, [5] carry
  - flag_code 4 bits; reg_dest 4 bits
  - branch_addr, next_pc: 32 bits each
  - alu_res, imm, mem_addr, mem_data: 32 bits each
REQ-005 Data-memory port:
  - dm_req  output  1: access request
  - dm_we  output  1: write enable
  - dm_addr, dm_wdata  output  32: address and write data
  - dm_rdata  input  32: read data
  - dm_ack  input  1: access complete
REQ-006 Control outputs:
  - branch_taken  output  1
  - branch_target  output  32
  - stall  output  1: freeze upstream
  - mem_err  output  1: sticky timeout flag
REQ-007 MEM/WB register outputs:
  - out_wb_res_mux 2 bits; out_reg_write_enable 1 bit; out_reg_dest 4 bits
  - out_alu_res, out_mem_rdata, out_next_pc, out_imm: 32 bits each

Function
REQ-008 An access is pending when mem_write_enable or mem_read_enable is 1 and state is IDLE; write has priority if both are set.
REQ-009 State machine, states IDLE and WAIT:
  - IDLE -> WAIT: access pending and dm_ack=0.
  - WAIT -> IDLE: dm_ack=1, or timeout counter reaches TIMEOUT-1.
  - All other cases: state unchanged.
REQ-010 Memory port drive (combinational):
  - dm_req=1 in IDLE with an access pending, and throughout WAIT.
  - dm_we = mem_write_enable.
  - dm_addr = mem_addr; dm_wdata = mem_data.
REQ-011 stall (combinational):
  - 1 in IDLE with access pending and dm_ack=0.
  - 1 in WAIT while dm_ack=0 and the counter is below TIMEOUT-1.
  - 0 otherwise; an access acknowledged in its first cycle does not stall.
REQ-012 Upstream holds all inputs stable while stall=1.
REQ-013 Timeout counter (8 bits):
  - Clears on entry to WAIT; increments each WAIT cycle without dm_ack.
  - Abort: mem_err set to 1 (sticky until rst); out_mem_rdata loads 0; the instruction retires normally.
REQ-014 MEM/WB register update:
  - stall=1: load a bubble (out_reg_write_enable=0; other fields hold).
  - stall=0: load all inputs; out_mem_rdata = dm_rdata on an acknowledged read, 0 on abort, held otherwise.
REQ-015 branch_taken is combinational = is_branch & cond & ~stall, where:
  - sel_jflag_branch=0: cond = flags[0] XOR sel_beq_bne (beq when 0, bne when 1).
  - sel_jflag_branch=1 and flag_code<=5: cond = flags[flag_code] XOR sel_jt_jf (jt when 0, jf when 1).
  - sel_jflag_branch=1 and flag_code>5: cond = 0.
REQ-016 branch_target = branch_addr, passed through combinationally.
REQ-017 Branches do not access memory; an instruction with is_branch and an access set performs the access and evaluates the branch in the cycle stall drops.

Reset
REQ-018 While rst=1:
  - State IDLE; counter 0; mem_err 0.
  - All out_* registers 0.
  - dm_req, stall, branch_taken: 0.
REQ-019 rst asserted during WAIT abandons the access immediately: dm_req drops, no WB write occurs, mem_err is not set.

Verification
REQ-020 Read, mem_addr=0x10, dm_ack=1 in the same cycle, dm_rdata=0xCAFEBABE -> stall never 1; next edge out_mem_rdata=0xCAFEBABE, out_reg_write_enable=1.
REQ-021 Write, dm_ack after 3 cycles -> stall=1 for exactly 3 cycles with bubbles in WB; dm_we=1; dm_wdata stable; instruction retires on the ack edge.
REQ-022 TIMEOUT=4, read, no ack -> stall=1 for 4 cycles, then mem_err=1, out_mem_rdata=0, state IDLE.
REQ-023 Branch checks:
  - beq with flags=0x01 -> branch_taken=1, branch_target=branch_addr.
  - bne with flags=0x01 -> 0.
  - jf, flag_code=5, flags=0x00 -> 1.
  - jt, flag_code=7 -> 0.
REQ-024 rst pulse in WAIT (cycle 2 of the access) -> all outputs 0 asynchronously, dm_req=0, mem_err=0; a new read after release completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port bundle between the MEM pipeline stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_rdata, dm_ack);
  modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access with ack/timeout handshake, branch resolution
// and the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write_enable,
  input  logic        mem_read_enable,
  input  logic        is_branch,
  input  logic        sel_jflag_branch,
  input  logic        sel_beq_bne,
  input  logic        sel_jt_jf,
  input  logic        reg_write_enable,
  input  logic [1:0]  wb_res_mux,
  input  logic [5:0]  flags,
  input  logic [3:0]  flag_code,
  input  logic [3:0]  reg_dest,
  input  logic [31:0] branch_addr,
  input  logic [31:0] next_pc,
  input  logic [31:0] alu_res,
  input  logic [31:0] imm,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  mem_stage_if.master dm,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic        mem_err,
  output logic [1:0]  out_wb_res_mux,
  output logic        out_reg_write_enable,
  output logic [3:0]  out_reg_dest,
  output logic [31:0] out_alu_res,
  output logic [31:0] out_mem_rdata,
  output logic [31:0] out_next_pc,
  output logic [31:0] out_imm
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        mem_err_reg;
  logic        stall_next, req_next, ack_done, abort;
  logic        is_read;
  logic [1:0]  wb_res_mux_reg;
  logic        reg_write_enable_reg;
  logic [3:0]  reg_dest_reg;
  logic [31:0] alu_res_reg, mem_rdata_reg, next_pc_reg, imm_reg;
  logic [5:0]  flag_hit;
  logic        cond;

  // Write wins when both enables are set, so only a pure read captures dm_rdata.
  assign is_read = mem_read_enable & ~mem_write_enable;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_next = 1'b0;
    req_next   = 1'b0;
    ack_done   = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (mem_write_enable | mem_read_enable) begin
          req_next = 1'b1;
          if (dm.dm_ack) begin
            ack_done = 1'b1;
          end else begin
            stall_next = 1'b1;
            state_next = S_WAIT;
            cnt_next   = 8'd0;
          end
        end
      end
      S_WAIT: begin
        req_next = 1'b1;
        if (dm.dm_ack) begin
          ack_done   = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_reg == LAST_CNT) begin
            abort      = 1'b1;
            state_next = S_IDLE;
          end else begin
            stall_next = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Flag selector for jt/jf: one-hot hit per implemented flag bit.
  for (genvar gi = 0; gi < 6; gi++) begin : g_flag
    assign flag_hit[gi] = (flag_code == 4'(gi)) & flags[gi];
  end

  always_comb begin
    cond = flags[0] ^ sel_beq_bne;
    if (sel_jflag_branch) begin
      cond = (flag_code <= 4'd5) ? ((|flag_hit) ^ sel_jt_jf) : 1'b0;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign stall         = stall_next & ~rst;
  assign branch_taken  = is_branch & cond & ~stall_next & ~rst;
  assign branch_target = branch_addr;
  assign dm.dm_req     = req_next & ~rst;
  assign dm.dm_we      = mem_write_enable;
  assign dm.dm_addr    = mem_addr;
  assign dm.dm_wdata   = mem_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg            <= S_IDLE;
      cnt_reg              <= 8'd0;
      mem_err_reg          <= 1'b0;
      wb_res_mux_reg       <= 2'd0;
      reg_write_enable_reg <= 1'b0;
      reg_dest_reg         <= 4'd0;
      alu_res_reg          <= 32'd0;
      mem_rdata_reg        <= 32'd0;
      next_pc_reg          <= 32'd0;
      imm_reg              <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (abort) begin
        mem_err_reg <= 1'b1;
      end
      if (stall_next) begin
        reg_write_enable_reg <= 1'b0;
      end else begin
        wb_res_mux_reg       <= wb_res_mux;
        reg_write_enable_reg <= reg_write_enable;
        reg_dest_reg         <= reg_dest;
        alu_res_reg          <= alu_res;
        next_pc_reg          <= next_pc;
        imm_reg              <= imm;
        if (abort) begin
          mem_rdata_reg <= 32'd0;
        end else if (ack_done & is_read) begin
          mem_rdata_reg <= dm.dm_rdata;
        end
      end
    end
  end

  assign mem_err              = mem_err_reg;
  assign out_wb_res_mux       = wb_res_mux_reg;
  assign out_reg_write_enable = reg_write_enable_reg;
  assign out_reg_dest         = reg_dest_reg;
  assign out_alu_res          = alu_res_reg;
  assign out_mem_rdata        = mem_rdata_reg;
  assign out_next_pc          = next_pc_reg;
  assign out_imm              = imm_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): ack-in-first-cycle read, delayed write,
// timeout abort, branch conditions and asynchronous reset in the middle of an access.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write_enable, mem_read_enable, is_branch, sel_jflag_branch;
  logic        sel_beq_bne, sel_jt_jf, reg_write_enable;
  logic [1:0]  wb_res_mux;
  logic [5:0]  flags;
  logic [3:0]  flag_code, reg_dest;
  logic [31:0] branch_addr, next_pc, alu_res, imm, mem_addr, mem_data;
  logic        branch_taken, stall, mem_err;
  logic [31:0] branch_target;
  logic [1:0]  out_wb_res_mux;
  logic        out_reg_write_enable;
  logic [3:0]  out_reg_dest;
  logic [31:0] out_alu_res, out_mem_rdata, out_next_pc, out_imm;

  int checks   = 0;
  int failures = 0;

  mem_stage_if dmi ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .is_branch(is_branch), .sel_jflag_branch(sel_jflag_branch),
    .sel_beq_bne(sel_beq_bne), .sel_jt_jf(sel_jt_jf),
    .reg_write_enable(reg_write_enable), .wb_res_mux(wb_res_mux),
    .flags(flags), .flag_code(flag_code), .reg_dest(reg_dest),
    .branch_addr(branch_addr), .next_pc(next_pc), .alu_res(alu_res), .imm(imm),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .dm(dmi.master),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .stall(stall), .mem_err(mem_err),
    .out_wb_res_mux(out_wb_res_mux), .out_reg_write_enable(out_reg_write_enable),
    .out_reg_dest(out_reg_dest), .out_alu_res(out_alu_res),
    .out_mem_rdata(out_mem_rdata), .out_next_pc(out_next_pc), .out_imm(out_imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_write_enable = 0; mem_read_enable = 0; is_branch = 0; sel_jflag_branch = 0;
    sel_beq_bne = 0; sel_jt_jf = 0; reg_write_enable = 0; wb_res_mux = 0;
    flags = 0; flag_code = 0; reg_dest = 0; branch_addr = 0; next_pc = 0;
    alu_res = 0; imm = 0; mem_addr = 0; mem_data = 0;
    dmi.dm_ack = 0; dmi.dm_rdata = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    mem_read_enable = 1;
    #1;
    // Reset holds everything quiet even with an access requested.
    check("rst_dm_req", {31'd0, dmi.dm_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_err", {31'd0, mem_err}, 32'd0);
    check("rst_out_rdata", out_mem_rdata, 32'd0);
    check("rst_out_rwe", {31'd0, out_reg_write_enable}, 32'd0);
    $display("txn reset: dm_req=%0b stall=%0b", dmi.dm_req, stall);
    tick(); tick();
    rst = 0;

    // Read acknowledged in its first cycle: no stall, data lands on the next edge.
    mem_read_enable = 1; mem_addr = 32'h10; reg_write_enable = 1; reg_dest = 4'd3;
    wb_res_mux = 2'd1; alu_res = 32'h1111; next_pc = 32'h104; imm = 32'h7;
    dmi.dm_ack = 1; dmi.dm_rdata = 32'hCAFEBABE;
    #1;
    check("rd_stall", {31'd0, stall}, 32'd0);
    check("rd_dm_req", {31'd0, dmi.dm_req}, 32'd1);
    check("rd_dm_addr", dmi.dm_addr, 32'h10);
    check("rd_dm_we", {31'd0, dmi.dm_we}, 32'd0);
    tick();
    check("rd_out_rdata", out_mem_rdata, 32'hCAFEBABE);
    check("rd_out_rwe", {31'd0, out_reg_write_enable}, 32'd1);
    check("rd_out_dest", {28'd0, out_reg_dest}, 32'd3);
    check("rd_out_wbmux", {30'd0, out_wb_res_mux}, 32'd1);
    check("rd_out_pc", out_next_pc, 32'h104);
    $display("txn read_ack0: rdata=%h rwe=%0b", out_mem_rdata, out_reg_write_enable);

    // Write acked after three stall cycles; WB sees bubbles meanwhile.
    clear_inputs();
    mem_write_enable = 1; mem_addr = 32'h20; mem_data = 32'h12345678;
    reg_write_enable = 1; reg_dest = 4'd9; alu_res = 32'h2222;
    dmi.dm_rdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("wr_stall_%0d", i), {31'd0, stall}, 32'd1);
      check($sformatf("wr_dm_we_%0d", i), {31'd0, dmi.dm_we}, 32'd1);
      check($sformatf("wr_wdata_%0d", i), dmi.dm_wdata, 32'h12345678);
      tick();
      check($sformatf("wr_bubble_%0d", i), {31'd0, out_reg_write_enable}, 32'd0);
    end
    dmi.dm_ack = 1;
    #1;
    check("wr_ack_stall", {31'd0, stall}, 32'd0);
    check("wr_ack_req", {31'd0, dmi.dm_req}, 32'd1);
    tick();
    check("wr_retire_rwe", {31'd0, out_reg_write_enable}, 32'd1);
    check("wr_retire_alu", out_alu_res, 32'h2222);
    check("wr_rdata_held", out_mem_rdata, 32'hCAFEBABE);
    check("wr_mem_err", {31'd0, mem_err}, 32'd0);
    $display("txn write_ack3: alu=%h rdata=%h", out_alu_res, out_mem_rdata);

    // Read that never gets acked: four stall cycles then abort.
    clear_inputs();
    mem_read_enable = 1; mem_addr = 32'h30; reg_write_enable = 1; reg_dest = 4'd5;
    dmi.dm_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("to_stall_%0d", i), {31'd0, stall}, 32'd1);
      tick();
    end
    #1;
    check("to_abort_stall", {31'd0, stall}, 32'd0);
    check("to_abort_req", {31'd0, dmi.dm_req}, 32'd1);
    tick();
    check("to_mem_err", {31'd0, mem_err}, 32'd1);
    check("to_rdata_zero", out_mem_rdata, 32'd0);
    check("to_retire_rwe", {31'd0, out_reg_write_enable}, 32'd1);
    check("to_retire_dest", {28'd0, out_reg_dest}, 32'd5);
    clear_inputs();
    #1;
    check("to_idle_req", {31'd0, dmi.dm_req}, 32'd0);
    tick();
    check("to_err_sticky", {31'd0, mem_err}, 32'd1);
    $display("txn read_timeout: mem_err=%0b rdata=%h", mem_err, out_mem_rdata);

    // Branch conditions with no memory access.
    is_branch = 1; branch_addr = 32'hABCD0000;
    flags = 6'h01; sel_beq_bne = 0;
    #1;
    check("br_beq_taken", {31'd0, branch_taken}, 32'd1);
    check("br_target", branch_target, 32'hABCD0000);
    sel_beq_bne = 1;
    #1;
    check("br_bne", {31'd0, branch_taken}, 32'd0);
    sel_jflag_branch = 1; sel_jt_jf = 1; flag_code = 4'd5; flags = 6'h00;
    #1;
    check("br_jf_fc5", {31'd0, branch_taken}, 32'd1);
    sel_jt_jf = 0; flags = 6'h20;
    #1;
    check("br_jt_carry", {31'd0, branch_taken}, 32'd1);
    flag_code = 4'd7; flags = 6'h3F;
    #1;
    check("br_jt_fc7", {31'd0, branch_taken}, 32'd0);
    $display("txn branches: target=%h", branch_target);
    tick();

    // Branch + read with no ack: branch suppressed while stalled; reset mid-access.
    clear_inputs();
    is_branch = 1; flags = 6'h01; branch_addr = 32'h400;
    mem_read_enable = 1; mem_addr = 32'h40; reg_write_enable = 1; reg_dest = 4'd6;
    #1;
    check("brst_stall", {31'd0, stall}, 32'd1);
    check("brst_taken", {31'd0, branch_taken}, 32'd0);
    tick();
    #1;
    check("brst_wait_stall", {31'd0, stall}, 32'd1);
    rst = 1;
    #1;
    check("arst_dm_req", {31'd0, dmi.dm_req}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_mem_err", {31'd0, mem_err}, 32'd0);
    check("arst_rwe", {31'd0, out_reg_write_enable}, 32'd0);
    check("arst_alu", out_alu_res, 32'd0);
    check("arst_pc", out_next_pc, 32'd0);
    check("arst_taken", {31'd0, branch_taken}, 32'd0);
    $display("txn async_reset: dm_req=%0b mem_err=%0b", dmi.dm_req, mem_err);
    tick();
    rst = 0;

    // Fresh read after reset: one stall cycle, then ack.
    clear_inputs();
    mem_read_enable = 1; mem_addr = 32'h50; reg_write_enable = 1; reg_dest = 4'd2;
    dmi.dm_rdata = 32'h0BADF00D;
    #1;
    check("post_stall", {31'd0, stall}, 32'd1);
    tick();
    dmi.dm_ack = 1;
    #1;
    check("post_ack_stall", {31'd0, stall}, 32'd0);
    tick();
    check("post_rdata", out_mem_rdata, 32'h0BADF00D);
    check("post_rwe", {31'd0, out_reg_write_enable}, 32'd1);
    check("post_mem_err", {31'd0, mem_err}, 32'd0);
    $display("txn read_after_reset: rdata=%h", out_mem_rdata);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
